// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage: performs one word access per request
// over LATENCY cycles, holding the pipeline with Stall and flagging illegal accesses.
module dmem_responder #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              Stall,
  output logic              AccessErr
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rd_q, wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic              req;
  logic              latch;
  logic              commit;
  logic              illegal;
  logic              cur_rd, cur_wr;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic [AW-1:0]     widx;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_comb begin
    req     = MemRead | MemWrite;
    latch   = 1'b0;
    state_d = state_q;
    cnt_d   = cnt_q;
    // In IDLE the live inputs are the request; afterwards only the latched copy counts.
    if (state_q == IDLE) begin
      cur_rd    = MemRead;
      cur_wr    = MemWrite;
      cur_addr  = Address;
      cur_wdata = WriteData;
    end else begin
      cur_rd    = rd_q;
      cur_wr    = wr_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
    end
    case (state_q)
      IDLE: begin
        if (req) begin
          latch   = 1'b1;
          cnt_d   = 4'(LATENCY - 1);
          state_d = (LATENCY == 1) ? DONE : BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    commit  = (state_d == DONE);
    illegal = (|cur_addr[1:0]) | (|cur_addr[ADDR_W-1:AW+2]) | (cur_rd & cur_wr);
    widx    = cur_addr[AW+1:2];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch) begin
        rd_q    <= MemRead;
        wr_q    <= MemWrite;
        addr_q  <= Address;
        wdata_q <= WriteData;
      end
      err_q <= commit & illegal;
      if (commit && cur_rd) rdata_q <= illegal ? '0 : mem_q[widx];
    end
  end

  // Array is not reset; reset held across the commit edge discards the write.
  always_ff @(posedge clk) begin
    if (!reset && commit && cur_wr && !illegal) mem_q[widx] <= cur_wdata;
  end

  assign Stall     = ~reset & (((state_q == IDLE) & req) | (state_q == BUSY));
  assign ReadData  = rdata_q;
  assign AccessErr = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with three instances at LATENCY 2, 1 and 4.
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic        rd_v [3];
  logic        wr_v [3];
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata_v [3];
  logic        stall_v [3];
  logic        err_v [3];
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .LATENCY(2)) u_l2 (
    .clk(clk), .reset(reset), .MemRead(rd_v[0]), .MemWrite(wr_v[0]), .Address(addr),
    .WriteData(wdata), .ReadData(rdata_v[0]), .Stall(stall_v[0]), .AccessErr(err_v[0]));

  dmem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset), .MemRead(rd_v[1]), .MemWrite(wr_v[1]), .Address(addr),
    .WriteData(wdata), .ReadData(rdata_v[1]), .Stall(stall_v[1]), .AccessErr(err_v[1]));

  dmem_responder #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .LATENCY(4)) u_l4 (
    .clk(clk), .reset(reset), .MemRead(rd_v[2]), .MemWrite(wr_v[2]), .Address(addr),
    .WriteData(wdata), .ReadData(rdata_v[2]), .Stall(stall_v[2]), .AccessErr(err_v[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int lat_of(input int w);
    return (w == 0) ? 2 : (w == 1) ? 1 : 4;
  endfunction

  // Caller is just after a rising edge in an IDLE cycle; returns just after the
  // rising edge of the IDLE cycle following DONE.
  task automatic req(input int w, input logic r, input logic wr, input logic [31:0] a,
                     input logic [31:0] d, input logic exp_err, input logic chk_rd,
                     input logic [31:0] exp_rd);
    rd_v[w] = r;
    wr_v[w] = wr;
    addr    = a;
    wdata   = d;
    #1;
    for (int k = 0; k < lat_of(w); k++) begin
      chk($sformatf("stall_hi[%0d]", k), 32'(stall_v[w]), 32'd1);
      @(posedge clk); #1;
    end
    chk("done_stall", 32'(stall_v[w]), 32'd0);
    chk("done_err", 32'(err_v[w]), 32'(exp_err));
    if (chk_rd) chk("done_rdata", rdata_v[w], exp_rd);
    rd_v[w] = 1'b0;
    wr_v[w] = 1'b0;
    @(posedge clk); #1;
    chk("idle_err", 32'(err_v[w]), 32'd0);
    chk("idle_stall", 32'(stall_v[w]), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rd_v[i] = 1'b0;
      wr_v[i] = 1'b0;
    end
    addr  = '0;
    wdata = '0;
    reset = 1'b1;
    rd_v[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_stall", 32'(stall_v[i]), 32'd0);
      chk("rst_rdata", rdata_v[i], 32'd0);
      chk("rst_err", 32'(err_v[i]), 32'd0);
    end
    rd_v[0] = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;

    // LATENCY=2: store then load
    req(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
    req(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);

    // LATENCY=1
    req(1, 1'b0, 1'b1, 32'h20, 32'h12345678, 1'b0, 1'b1, 32'h0);
    req(1, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b1, 32'h12345678);

    // misaligned store is suppressed and leaves ReadData alone
    req(0, 1'b0, 1'b1, 32'h13, 32'hFFFFFFFF, 1'b1, 1'b1, 32'hDEADBEEF);
    req(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);

    // out-of-range load and read+write conflict
    req(0, 1'b0, 1'b1, 32'h0, 32'h5A5A5A5A, 1'b0, 1'b0, 32'h0);
    req(0, 1'b1, 1'b0, 32'h400, 32'h0, 1'b1, 1'b1, 32'h0);
    req(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);
    req(0, 1'b1, 1'b1, 32'h0, 32'hFFFF0000, 1'b1, 1'b1, 32'h0);
    req(0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h5A5A5A5A);
    req(0, 1'b1, 1'b0, 32'h3FC, 32'h0, 1'b0, 1'b0, 32'h0);

    // idle pipeline: nothing moves
    req(0, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h5A5A5A5A);
    for (int i = 0; i < 10; i++) begin
      chk("idle_run_stall", 32'(stall_v[0]), 32'd0);
      chk("idle_run_err", 32'(err_v[0]), 32'd0);
      chk("idle_run_rdata", rdata_v[0], 32'h5A5A5A5A);
      @(posedge clk); #1;
    end

    // LATENCY=4: reset in the 2nd BUSY cycle aborts a store
    req(2, 1'b0, 1'b1, 32'h8, 32'h11111111, 1'b0, 1'b0, 32'h0);
    req(2, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 1'b1, 32'h11111111);
    wr_v[2] = 1'b1;
    addr    = 32'h8;
    wdata   = 32'hCAFEF00D;
    #1;
    chk("l4_stall_idle", 32'(stall_v[2]), 32'd1);
    @(posedge clk); #1;
    chk("l4_stall_busy1", 32'(stall_v[2]), 32'd1);
    @(posedge clk); #1;
    chk("l4_stall_busy2", 32'(stall_v[2]), 32'd1);
    reset   = 1'b1;
    wr_v[2] = 1'b0;
    #1;
    chk("l4_abort_stall", 32'(stall_v[2]), 32'd0);
    chk("l4_abort_rdata", rdata_v[2], 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("l4_post_stall", 32'(stall_v[2]), 32'd0);
    req(2, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0, 1'b1, 32'h11111111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the MEM stage of the five-stage pipeline.
- Consumes the MemRead/MemWrite/Address/WriteData request produced by main control and the EX/MEM register, and performs the word access over a configurable multi-cycle latency.
- Holds the pipeline with Stall until the access completes, then returns read data to MEM/WB.
- Flags illegal accesses instead of performing them.

Parameters:
- DATA_W, 32, data word width.
- ADDR_W, 32, byte-address width.
- DEPTH, 256, number of words in the memory array; must be a power of 2.
- LATENCY, 2, access cycles per request; legal range 1..15.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- MemRead  input  1  load request from MEM stage.
- MemWrite  input  1  store request from MEM stage.
- Address  input  ADDR_W  byte address (ALU result).
- WriteData  input  DATA_W  store data.
- ReadData  output  DATA_W  registered load result to MEM/WB.
- Stall  output  1  freeze PC/IF/ID/EX/MEM registers while high.
- AccessErr  output  1  one-cycle pulse: the completed request was illegal.

Behaviour:
- Reset:
  - State IDLE, ReadData=0, AccessErr=0, latched request cleared.
  - Stall forced 0 while reset is high.
  - Memory array contents are not modified by reset.
- States: IDLE, BUSY, DONE. Down-counter cnt is 4 bits wide.
- IDLE:
  - req = MemRead | MemWrite.
  - Stall = req (combinational).
  - If req: latch op, Address and WriteData; cnt <= LATENCY-1.
  - Next state is DONE if LATENCY==1, otherwise BUSY.
- BUSY:
  - Stall=1; inputs are ignored and the latched copy is used.
  - cnt decrements each cycle; when cnt==1, next state is DONE.
- Access commit happens on the clock edge entering DONE:
  - Write: mem[word] <= latched data.
  - Read: ReadData <= mem[word].
  - AccessErr <= illegal.
- DONE:
  - Stall=0, so the pipeline advances at the end of this cycle.
  - Inputs still show the completed instruction and are ignored.
  - Next state IDLE unconditionally; AccessErr returns to 0.
- Timing:
  - A request first seen in IDLE at cycle T gives Stall high for cycles T..T+LATENCY-1.
  - DONE occurs at T+LATENCY, with ReadData valid in that cycle.
  - Back-to-back requests: the next request is accepted in the IDLE cycle after DONE, so there is no idle gap beyond that.
- ReadData holds its value until the next legal or illegal read completes; writes do not change it.
- Word index = Address[log2(DEPTH)+1:2].
- Illegal request, evaluated on latched values:
  - Address[1:0] != 0 (misaligned), or
  - Address >= DEPTH*4 (out of range), or
  - MemRead and MemWrite both high.
- Illegal request handling:
  - Full LATENCY stall still applies.
  - Write is suppressed; read returns ReadData=0.
  - AccessErr pulses in DONE.
- Reset mid-operation (in BUSY or DONE): the access is aborted and any pending write is discarded; the next cycle is IDLE.
- MemRead/MemWrite must be 0 or 1. Unknown values from undecoded opcodes are outside the contract; the bench must not drive X.

Test Plan:
- LATENCY=2, sw 0xDEADBEEF to 0x10 then lw 0x10 -> each request gives Stall high 2 cycles then DONE; the load's DONE cycle shows ReadData=0xDEADBEEF, AccessErr=0.
- LATENCY=1, lw from 0x20 after sw 0x12345678 there -> Stall high exactly 1 cycle per request; ReadData=0x12345678 in the following cycle.
- Misaligned sw 0xFFFFFFFF to 0x13 (word at 0x10 holds 0xDEADBEEF) -> AccessErr pulse in DONE; subsequent lw 0x10 returns 0xDEADBEEF.
- DEPTH=256, lw 0x400, then request with MemRead=MemWrite=1 at 0x0 -> each gives AccessErr=1 in its DONE cycle and ReadData=0; mem[0] unchanged.
- LATENCY=4, sw 0xCAFEF00D to 0x8, assert reset in 2nd BUSY cycle -> Stall=0 and ReadData=0 immediately; after release, lw 0x8 returns prior contents, not 0xCAFEF00D.
- Idle pipeline (MemRead=MemWrite=0) for 10 cycles -> Stall=0, AccessErr=0, ReadData unchanged throughout.
